// File: rtl/sl_rx_ctrl_if.sv
// Host/receiver signal bundle for sl_rx_ctrl: config apply handshake, receiver
// config/status taps and the event FIFO read port.
interface sl_rx_ctrl_if #(
  parameter int FIFO_AW = 2
);
  logic              cfg_wr;
  logic [15:0]       cfg_data;
  logic              cfg_busy;
  logic              cfg_done;
  logic              cfg_err;
  logic [15:0]       rx_wr_config_w;
  logic              rx_wr_enable;
  logic [15:0]       rx_config_w;
  logic [15:0]       rx_status_w;
  logic [31:0]       rx_data_w;
  logic              rx_changed;
  logic              rd_en;
  logic [31:0]       rd_data;
  logic [2:0]        rd_flags;
  logic              fifo_empty;
  logic [FIFO_AW:0]  fifo_count;
  logic              ovf;
  logic              irq;
  logic              irq_clr;

  modport slave (
    input  cfg_wr, cfg_data, rx_config_w, rx_status_w, rx_data_w, rx_changed,
           rd_en, irq_clr,
    output cfg_busy, cfg_done, cfg_err, rx_wr_config_w, rx_wr_enable,
           rd_data, rd_flags, fifo_empty, fifo_count, ovf, irq
  );

  modport master (
    output cfg_wr, cfg_data, rx_config_w, rx_status_w, rx_data_w, rx_changed,
           rd_en, irq_clr,
    input  cfg_busy, cfg_done, cfg_err, rx_wr_config_w, rx_wr_enable,
           rd_data, rd_flags, fifo_empty, fifo_count, ovf, irq
  );
endinterface

// File: rtl/sl_rx_ctrl.sv
// Host-side controller for one SL receiver: timed config apply FSM, show-ahead
// event FIFO fed by receiver word events, and interrupt generation.
module sl_rx_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter int FIFO_AW     = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input logic    clk,
    input logic    rst_n,
    sl_rx_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, APPLY, DONE, ERR} state_t;

    localparam logic [15:0]      TMO_LAST  = 16'(TIMEOUT_CYC - 1);
    localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW + 1)'(FIFO_DEPTH);

    state_t      state, state_nx;
    logic [15:0] cfg_q;
    logic [15:0] tmo_cnt;
    logic [5:0]  bq;
    logic        cfg_ok;
    logic        cfg_match;

    assign bq        = bus.cfg_data[6:1];
    assign cfg_ok    = (bq >= 6'd8) && (bq <= 6'd32) && !bq[0];
    assign cfg_match = (bus.rx_config_w == cfg_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.cfg_wr) state_nx = cfg_ok ? APPLY : ERR;
            APPLY:   if (cfg_match) state_nx = DONE;
                     else if (tmo_cnt == TMO_LAST) state_nx = ERR;
            DONE:    state_nx = IDLE;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q   <= 16'h0010;
            tmo_cnt <= '0;
        end else if (state == IDLE && bus.cfg_wr && cfg_ok) begin
            cfg_q   <= bus.cfg_data;
            tmo_cnt <= '0;
        end else if (state == APPLY && !cfg_match && tmo_cnt != TMO_LAST) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    assign bus.cfg_busy       = (state == APPLY);
    assign bus.rx_wr_enable   = (state == APPLY);
    assign bus.cfg_done       = (state == DONE);
    assign bus.cfg_err        = (state == ERR);
    assign bus.rx_wr_config_w = cfg_q;

    // Entry layout: {LEF, PEF, WLC, data[31:0]}
    logic [34:0]        mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               push_req, push, pop, drop, empty, full;
    logic [34:0]        push_entry, head;
    logic               irq_err;
    logic               irqm;

    always_comb begin
        push_req   = 1'b0;
        push_entry = '0;
        if (bus.rx_changed) begin
            if (bus.rx_status_w[3]) begin
                push_req   = 1'b1;
                push_entry = {1'b0, bus.rx_status_w[4], bus.rx_status_w[0],
                              bus.rx_status_w[0] ? 32'h0 : bus.rx_data_w};
            end else if (bus.rx_status_w[5]) begin
                push_req   = 1'b1;
                push_entry = {3'b100, 32'h0};
            end
        end
    end

    assign empty = (count == '0);
    assign full  = (count == DEPTH_CNT);
    assign pop   = bus.rd_en && !empty;
    // A pop frees the slot this cycle, so a full FIFO still accepts a push alongside it.
    assign push  = push_req && (!full || pop);
    assign drop  = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head           = mem[rd_ptr];
    assign bus.rd_data    = empty ? 32'h0 : head[31:0];
    assign bus.rd_flags   = empty ? 3'b000 : head[34:32];
    assign bus.fifo_empty = empty;
    assign bus.fifo_count = count;

    assign irqm = bus.rx_config_w[8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ovf <= 1'b0;
            irq_err <= 1'b0;
        end else begin
            if (drop)             bus.ovf <= 1'b1;
            else if (bus.irq_clr) bus.ovf <= 1'b0;
            if (irqm && push && (|push_entry[34:32])) irq_err <= 1'b1;
            else if (bus.irq_clr)                     irq_err <= 1'b0;
        end
    end

    assign bus.irq = irqm ? (irq_err | bus.ovf) : (!empty | bus.ovf);

endmodule

// File: tb/tb_sl_rx_ctrl.sv
// Self-checking bench for sl_rx_ctrl: directed config scenarios plus randomized
// event/pop traffic compared against a queue-based FIFO/IRQ reference model.
module tb_sl_rx_ctrl;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model state
    bit [34:0] mq[$];
    bit        m_ovf;
    bit        m_irq_err;

    sl_rx_ctrl_if #(.FIFO_AW(2)) bus ();

    sl_rx_ctrl #(.FIFO_DEPTH(DEPTH), .FIFO_AW(2), .TIMEOUT_CYC(TMO)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance one clock while tracking the expected FIFO/ovf/irq_err effects of the current inputs.
    task automatic step();
        bit [34:0] e;
        bit        req;
        bit        accepted;
        bit        dropped;
        req = 0; e = '0; accepted = 0; dropped = 0;
        if (bus.rx_changed === 1'b1) begin
            if (bus.rx_status_w[3]) begin
                req = 1;
                e[34]   = 1'b0;
                e[33]   = bus.rx_status_w[4];
                e[32]   = bus.rx_status_w[0];
                e[31:0] = bus.rx_status_w[0] ? 32'd0 : bus.rx_data_w;
            end else if (bus.rx_status_w[5]) begin
                req = 1;
                e = {3'b100, 32'd0};
            end
        end
        if (bus.rd_en && mq.size() > 0) void'(mq.pop_front());
        if (req) begin
            if (mq.size() < DEPTH) begin mq.push_back(e); accepted = 1; end
            else dropped = 1;
        end
        if (bus.irq_clr) begin m_ovf = 0; m_irq_err = 0; end
        if (dropped) m_ovf = 1;
        if (accepted && bus.rx_config_w[8] && e[34:32] != 3'b000) m_irq_err = 1;
        tick();
    endtask

    task automatic clear_inputs();
        bus.cfg_wr = 0; bus.cfg_data = '0; bus.rx_config_w = '0; bus.rx_status_w = '0;
        bus.rx_data_w = '0; bus.rx_changed = 0; bus.rd_en = 0; bus.irq_clr = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        #13;
        @(negedge clk);
        rst_n = 1;
        mq.delete(); m_ovf = 0; m_irq_err = 0;
        tick();
    endtask

    task automatic push_ev(input logic [15:0] st, input logic [31:0] d, input logic pop_too);
        bus.rx_status_w = st; bus.rx_data_w = d; bus.rx_changed = 1; bus.rd_en = pop_too;
        step();
        bus.rx_changed = 0; bus.rx_status_w = '0; bus.rd_en = 0;
    endtask

    task automatic pop_ev();
        bus.rd_en = 1;
        step();
        bus.rd_en = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.cfg_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.cfg_busy); end
        checks++; if (bus.cfg_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.cfg_done); end
        checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.cfg_err); end
        checks++; if (bus.rx_wr_enable !== 1'b0) begin errors++; $display("FAIL reset_wren got %b want 0", bus.rx_wr_enable); end
        checks++; if (bus.rx_wr_config_w !== 16'h0010) begin errors++; $display("FAIL reset_wrcfg got %h want 0010", bus.rx_wr_config_w); end
        checks++; if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", bus.fifo_empty); end
        checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.fifo_count); end
        checks++; if (bus.rd_data !== 32'h0 || bus.rd_flags !== 3'b000) begin errors++; $display("FAIL reset_head got %h/%b want 0/000", bus.rd_data, bus.rd_flags); end
        checks++; if (bus.ovf !== 1'b0 || bus.irq !== 1'b0) begin errors++; $display("FAIL reset_irq got ovf=%b irq=%b want 0/0", bus.ovf, bus.irq); end
    endtask

    // Receiver accepts after 5 cycles of wr_enable; the 6th APPLY cycle sees the match.
    task automatic test_cfg_apply(input logic [15:0] cfg);
        int unsigned busy_n, done_n, err_n, wren_bad;
        bus.rx_config_w = 16'h0000;
        bus.cfg_data = cfg; bus.cfg_wr = 1;
        tick();
        bus.cfg_wr = 0;
        busy_n = 0; done_n = 0; err_n = 0; wren_bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy_n == 5) bus.rx_config_w = cfg;
            if (bus.cfg_err) err_n++;
            if (bus.cfg_done) begin done_n++; break; end
            if (bus.cfg_busy) begin
                busy_n++;
                if (bus.rx_wr_enable !== 1'b1 || bus.rx_wr_config_w !== cfg) wren_bad++;
            end
            tick();
        end
        checks++; if (done_n != 1) begin errors++; $display("FAIL apply_done got %0d want 1", done_n); end
        checks++; if (busy_n != 6) begin errors++; $display("FAIL apply_busy_cycles got %0d want 6", busy_n); end
        checks++; if (wren_bad != 0 || err_n != 0) begin errors++; $display("FAIL apply_wren got bad=%0d err=%0d want 0/0", wren_bad, err_n); end
        checks++; if (bus.rx_wr_enable !== 1'b0 || bus.cfg_busy !== 1'b0) begin errors++; $display("FAIL apply_drop got en=%b busy=%b want 0/0", bus.rx_wr_enable, bus.cfg_busy); end
        tick();
        checks++; if (bus.cfg_done !== 1'b0 || bus.rx_wr_config_w !== cfg) begin errors++; $display("FAIL apply_after got done=%b cfg=%h want 0/%h", bus.cfg_done, bus.rx_wr_config_w, cfg); end
        bus.rx_config_w = 16'h0000;
    endtask

    task automatic test_cfg_invalid();
        logic [15:0] bad [4];
        logic [15:0] held;
        bad[0] = 16'h000E; bad[1] = 16'h000C; bad[2] = 16'h0044; bad[3] = 16'h0042;
        held = bus.rx_wr_config_w;
        foreach (bad[k]) begin
            bus.cfg_data = bad[k]; bus.cfg_wr = 1;
            tick();
            bus.cfg_wr = 0;
            checks++; if (bus.cfg_err !== 1'b1 || bus.rx_wr_enable !== 1'b0 || bus.cfg_busy !== 1'b0)
                begin errors++; $display("FAIL invalid_err cfg=%h got err=%b en=%b busy=%b want 1/0/0", bad[k], bus.cfg_err, bus.rx_wr_enable, bus.cfg_busy); end
            tick();
            checks++; if (bus.cfg_err !== 1'b0 || bus.rx_wr_config_w !== held)
                begin errors++; $display("FAIL invalid_after cfg=%h got err=%b wcfg=%h want 0/%h", bad[k], bus.cfg_err, bus.rx_wr_config_w, held); end
        end
    endtask

    task automatic test_timeout();
        int unsigned busy_n, err_n, done_n;
        bus.rx_config_w = 16'h0000;
        bus.cfg_data = 16'h0020; bus.cfg_wr = 1;
        tick();
        bus.cfg_wr = 0;
        busy_n = 0; err_n = 0; done_n = 0;
        for (int i = 0; i < 60; i++) begin
            // A stray invalid request mid-apply must be ignored.
            bus.cfg_wr = (busy_n == 3);
            bus.cfg_data = (busy_n == 3) ? 16'h000E : 16'h0020;
            if (bus.cfg_done) done_n++;
            if (bus.cfg_err) begin err_n++; break; end
            if (bus.cfg_busy) busy_n++;
            tick();
        end
        bus.cfg_wr = 0;
        checks++; if (err_n != 1 || done_n != 0) begin errors++; $display("FAIL timeout_err got err=%0d done=%0d want 1/0", err_n, done_n); end
        checks++; if (busy_n != TMO) begin errors++; $display("FAIL timeout_cycles got %0d want %0d", busy_n, TMO); end
        tick();
        checks++; if (bus.cfg_busy !== 1'b0 || bus.cfg_err !== 1'b0) begin errors++; $display("FAIL timeout_idle got busy=%b err=%b want 0/0", bus.cfg_busy, bus.cfg_err); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 5; i++) push_ev(16'h0008, 32'(i), 1'b0);
        checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d want 4", bus.fifo_count); end
        checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", bus.ovf); end
        for (int i = 1; i <= 4; i++) begin
            checks++; if (bus.rd_data !== 32'(i) || bus.rd_flags !== 3'b000) begin errors++; $display("FAIL ovf_pop%0d got %h/%b want %h/000", i, bus.rd_data, bus.rd_flags, i); end
            pop_ev();
        end
        checks++; if (bus.fifo_empty !== 1'b1 || bus.rd_data !== 32'h0) begin errors++; $display("FAIL ovf_empty got e=%b d=%h want 1/0", bus.fifo_empty, bus.rd_data); end
        pop_ev();
        checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL pop_empty_count got %0d want 0", bus.fifo_count); end
        bus.irq_clr = 1; step(); bus.irq_clr = 0;
        checks++; if (bus.ovf !== 1'b0 || bus.irq !== 1'b0) begin errors++; $display("FAIL ovf_clr got ovf=%b irq=%b want 0/0", bus.ovf, bus.irq); end
    endtask

    task automatic test_irq();
        do_reset();
        bus.rx_config_w = 16'h0100;
        push_ev(16'h0018, 32'hCAFE_0001, 1'b0);
        checks++; if (bus.irq !== 1'b1 || bus.rd_flags !== 3'b010) begin errors++; $display("FAIL irqm1_set got irq=%b fl=%b want 1/010", bus.irq, bus.rd_flags); end
        pop_ev();
        checks++; if (bus.irq !== 1'b1 || bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL irqm1_sticky got irq=%b e=%b want 1/1", bus.irq, bus.fifo_empty); end
        bus.irq_clr = 1; step(); bus.irq_clr = 0;
        checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL irqm1_clr got %b want 0", bus.irq); end
        push_ev(16'h0008, 32'h1234, 1'b0);
        checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL irqm1_noflag got %b want 0", bus.irq); end
        pop_ev();
        bus.rx_config_w = 16'h0000;
        push_ev(16'h0009, 32'hDEAD_BEEF, 1'b0);
        checks++; if (bus.irq !== 1'b1 || bus.rd_data !== 32'h0 || bus.rd_flags !== 3'b001) begin errors++; $display("FAIL irqm0_wlc got irq=%b d=%h fl=%b want 1/0/001", bus.irq, bus.rd_data, bus.rd_flags); end
        pop_ev();
        checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL irqm0_empty got %b want 0", bus.irq); end
        push_ev(16'h0020, 32'h5555_5555, 1'b0);
        push_ev(16'h0002, 32'h7777_7777, 1'b0);
        checks++; if (bus.fifo_count !== 3'd1 || bus.rd_flags !== 3'b100 || bus.rd_data !== 32'h0) begin errors++; $display("FAIL lef_entry got c=%0d fl=%b d=%h want 1/100/0", bus.fifo_count, bus.rd_flags, bus.rd_data); end
        pop_ev();
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 4; i++) push_ev(16'h0008, 32'h100 + 32'(i), 1'b0);
        push_ev(16'h0008, 32'h200, 1'b1);
        checks++; if (bus.fifo_count !== 3'd4 || bus.ovf !== 1'b0) begin errors++; $display("FAIL fullpp got c=%0d ovf=%b want 4/0", bus.fifo_count, bus.ovf); end
        checks++; if (bus.rd_data !== 32'h101) begin errors++; $display("FAIL fullpp_head got %h want 00000101", bus.rd_data); end
        for (int i = 0; i < 3; i++) pop_ev();
        checks++; if (bus.rd_data !== 32'h200 || bus.fifo_count !== 3'd1) begin errors++; $display("FAIL fullpp_tail got %h c=%0d want 00000200/1", bus.rd_data, bus.fifo_count); end
        pop_ev();
    endtask

    task automatic test_random();
        bit [34:0] h;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (n % 100 == 0) bus.rx_config_w = {7'd0, 1'($urandom_range(0, 1)), 8'd0};
            bus.rx_changed  = ($urandom_range(0, 99) < 55);
            bus.rx_status_w = 16'(($urandom_range(0, 1) << 5) | ($urandom_range(0, 1) << 4) |
                                  ($urandom_range(0, 1) << 3) | ($urandom_range(0, 1) << 1) |
                                  $urandom_range(0, 1));
            bus.rx_data_w   = $urandom;
            bus.rd_en       = ($urandom_range(0, 99) < 40);
            bus.irq_clr     = ($urandom_range(0, 99) < 8);
            step();
            h = (mq.size() > 0) ? mq[0] : 35'd0;
            checks++;
            if (bus.fifo_count !== 3'(mq.size()) || bus.rd_data !== h[31:0] || bus.rd_flags !== h[34:32] ||
                bus.fifo_empty !== (mq.size() == 0) || bus.ovf !== m_ovf ||
                bus.irq !== (bus.rx_config_w[8] ? (m_irq_err | m_ovf) : ((mq.size() != 0) | m_ovf))) begin
                errors++;
                $display("FAIL rand_cycle%0d got c=%0d d=%h fl=%b ovf=%b irq=%b want c=%0d d=%h fl=%b ovf=%b ierr=%b",
                         n, bus.fifo_count, bus.rd_data, bus.rd_flags, bus.ovf, bus.irq,
                         mq.size(), h[31:0], h[34:32], m_ovf, m_irq_err);
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_apply();
        int unsigned ev_n;
        do_reset();
        push_ev(16'h0008, 32'hABCD, 1'b0);
        bus.cfg_data = 16'h0041; bus.cfg_wr = 1;
        tick();
        bus.cfg_wr = 0;
        tick(); tick();
        checks++; if (bus.cfg_busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", bus.cfg_busy); end
        #2 rst_n = 0;
        #1;
        checks++; if (bus.cfg_busy !== 1'b0 || bus.rx_wr_enable !== 1'b0 || bus.rx_wr_config_w !== 16'h0010)
            begin errors++; $display("FAIL mid_rst_cfg got busy=%b en=%b cfg=%h want 0/0/0010", bus.cfg_busy, bus.rx_wr_enable, bus.rx_wr_config_w); end
        checks++; if (bus.fifo_count !== 3'd0 || bus.fifo_empty !== 1'b1 || bus.rd_data !== 32'h0 || bus.ovf !== 1'b0 || bus.irq !== 1'b0)
            begin errors++; $display("FAIL mid_rst_fifo got c=%0d e=%b d=%h ovf=%b irq=%b want 0/1/0/0/0", bus.fifo_count, bus.fifo_empty, bus.rd_data, bus.ovf, bus.irq); end
        @(negedge clk);
        rst_n = 1;
        mq.delete(); m_ovf = 0; m_irq_err = 0;
        ev_n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.cfg_done || bus.cfg_err || bus.cfg_busy) ev_n++;
        end
        checks++; if (ev_n != 0) begin errors++; $display("FAIL mid_rst_quiet got %0d events want 0", ev_n); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_cfg_apply(16'h0010);
        test_cfg_apply(16'h0041);
        test_timeout();
        test_cfg_invalid();
        test_overflow();
        test_irq();
        test_full_push_pop();
        test_random();
        test_reset_mid_apply();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
